// File: rtl/scores_writer.sv
// Writes the finished game's score to the SD card once, and only when it beats the stored best.
// Optional request timeout with retries is enabled by defining SCORES_WRITE_TIMEOUT_EN.
module scores_writer #(
    parameter logic [31:0] SCORES_WRITE_ADDRESS = 32'h0000_0000
`ifdef SCORES_WRITE_TIMEOUT_EN
    ,
    parameter int unsigned REQUEST_TIMEOUT = 1_000_000,
    parameter int unsigned MAX_RETRIES     = 3
`endif
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        TO_SAVE,
    input  logic [15:0] CURRENT_SCORES,
    input  logic [15:0] PREVIOUS_SCORES,
    input  logic        SD_HAS_INITIALIZED,
    input  logic        SD_IS_WRITING,
    output logic        SD_TO_WRITE,
    output logic [31:0] SD_WRITE_ADDRESS,
    output logic [15:0] WRITE_DATA,
    output logic        WRITE_FINISH,
    output logic        SKIPPED,
    output logic        WRITE_ERROR
);

    // Handshake: SD_TO_WRITE is held high until the controller answers with SD_IS_WRITING;
    // the write is complete once SD_IS_WRITING falls again.
    typedef enum logic [2:0] {
        S_IDLE, S_COMPARE, S_REQUEST, S_WAIT_WRITE, S_DONE, S_BACKOFF
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cur_q, cur_d;
    logic [15:0] prev_q, prev_d;
    logic [15:0] data_q, data_d;
    logic        to_write_q, to_write_d;
    logic        finish_q, finish_d;
    logic        skipped_q, skipped_d;
    logic        error_q, error_d;
`ifdef SCORES_WRITE_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] retries_q, retries_d;
`endif

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        prev_d    = prev_q;
        data_d    = data_q;
        skipped_d = skipped_q;
        error_d   = error_q;
`ifdef SCORES_WRITE_TIMEOUT_EN
        cnt_d     = cnt_q;
        retries_d = retries_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (TO_SAVE && SD_HAS_INITIALIZED && !SD_IS_WRITING) begin
                    cur_d   = CURRENT_SCORES;
                    prev_d  = PREVIOUS_SCORES;
                    data_d  = CURRENT_SCORES;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (cur_q > prev_q) begin
                    state_d = S_REQUEST;
`ifdef SCORES_WRITE_TIMEOUT_EN
                    cnt_d   = 32'd0;
`endif
                end else begin
                    state_d   = S_DONE;
                    skipped_d = 1'b1;
                end
            end
            S_REQUEST: begin
                if (SD_IS_WRITING) begin
                    state_d = S_WAIT_WRITE;
                end
`ifdef SCORES_WRITE_TIMEOUT_EN
                else if (cnt_q == 32'(REQUEST_TIMEOUT - 1)) begin
                    if (retries_q < 32'(MAX_RETRIES)) begin
                        state_d   = S_BACKOFF;
                        retries_d = retries_q + 32'd1;
                    end else begin
                        state_d = S_DONE;
                        error_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
`ifdef SCORES_WRITE_TIMEOUT_EN
            S_BACKOFF: begin
                state_d = S_REQUEST;
                cnt_d   = 32'd0;
            end
`endif
            S_WAIT_WRITE: begin
                if (!SD_IS_WRITING) state_d = S_DONE;
            end
            S_DONE:  state_d = S_DONE;  // one write per game; only RESET leaves
            default: state_d = S_IDLE;
        endcase
        to_write_d = (state_d == S_REQUEST);
        finish_d   = (state_d == S_DONE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cur_q      <= 16'd0;
            prev_q     <= 16'd0;
            data_q     <= 16'd0;
            to_write_q <= 1'b0;
            finish_q   <= 1'b0;
            skipped_q  <= 1'b0;
            error_q    <= 1'b0;
`ifdef SCORES_WRITE_TIMEOUT_EN
            cnt_q      <= 32'd0;
            retries_q  <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            prev_q     <= prev_d;
            data_q     <= data_d;
            to_write_q <= to_write_d;
            finish_q   <= finish_d;
            skipped_q  <= skipped_d;
            error_q    <= error_d;
`ifdef SCORES_WRITE_TIMEOUT_EN
            cnt_q      <= cnt_d;
            retries_q  <= retries_d;
`endif
        end
    end

    assign SD_TO_WRITE      = to_write_q;
    assign SD_WRITE_ADDRESS = SCORES_WRITE_ADDRESS;
    assign WRITE_DATA       = data_q;
    assign WRITE_FINISH     = finish_q;
    assign SKIPPED          = skipped_q;
`ifdef SCORES_WRITE_TIMEOUT_EN
    assign WRITE_ERROR      = error_q;
`else
    assign WRITE_ERROR      = 1'b0;
    logic unused_error;
    assign unused_error     = error_q;
`endif

endmodule

// File: tb/tb_scores_writer.sv
// Randomized bench for scores_writer: an SD controller model plus a per-game outcome model.
// Define SCORES_WRITE_TIMEOUT_EN to also exercise the retry/timeout path.
module tb_scores_writer;

    localparam logic [31:0] ADDR   = 32'h0000_1A40;
    localparam int          REQ_TO = 10;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        TO_SAVE = 1'b0;
    logic [15:0] CURRENT_SCORES = 16'd0;
    logic [15:0] PREVIOUS_SCORES = 16'd0;
    logic        SD_HAS_INITIALIZED = 1'b1;
    logic        SD_IS_WRITING = 1'b0;
    logic        SD_TO_WRITE;
    logic [31:0] SD_WRITE_ADDRESS;
    logic [15:0] WRITE_DATA;
    logic        WRITE_FINISH;
    logic        SKIPPED;
    logic        WRITE_ERROR;

`ifdef SCORES_WRITE_TIMEOUT_EN
    scores_writer #(.SCORES_WRITE_ADDRESS(ADDR), .REQUEST_TIMEOUT(REQ_TO), .MAX_RETRIES(3)) dut (
`else
    scores_writer #(.SCORES_WRITE_ADDRESS(ADDR)) dut (
`endif
        .CLK(CLK), .RESET(RESET), .TO_SAVE(TO_SAVE),
        .CURRENT_SCORES(CURRENT_SCORES), .PREVIOUS_SCORES(PREVIOUS_SCORES),
        .SD_HAS_INITIALIZED(SD_HAS_INITIALIZED), .SD_IS_WRITING(SD_IS_WRITING),
        .SD_TO_WRITE(SD_TO_WRITE), .SD_WRITE_ADDRESS(SD_WRITE_ADDRESS),
        .WRITE_DATA(WRITE_DATA), .WRITE_FINISH(WRITE_FINISH),
        .SKIPPED(SKIPPED), .WRITE_ERROR(WRITE_ERROR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // SD controller model: answers a request one cycle later and stays busy busy_len cycles.
    int          busy_cnt   = 0;
    int          busy_len   = 1;
    bit          sd_respond = 1'b1;
    int          req_pulses = 0;
    int          hi_run     = 0;
    bit          prev_req   = 1'b0;
    logic [15:0] exp_data   = 16'd0;

    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (SD_TO_WRITE && !prev_req) req_pulses++;
            if (SD_TO_WRITE) begin
                hi_run++;
                check("req_addr", SD_WRITE_ADDRESS, ADDR);
                check("req_data", 32'(WRITE_DATA), 32'(exp_data));
            end else begin
                if (prev_req && !sd_respond) check("window_len", hi_run, REQ_TO);
                hi_run = 0;
            end
            prev_req = SD_TO_WRITE;
            if (busy_cnt > 0) busy_cnt--;
            else if (SD_TO_WRITE && sd_respond) busy_cnt = busy_len;
            SD_IS_WRITING = (busy_cnt > 0);
        end
    end

    task automatic do_reset();
        RESET = 1'b1;
        TO_SAVE = 1'b1;
        SD_HAS_INITIALIZED = 1'b1;
        CURRENT_SCORES = 16'd9;
        PREVIOUS_SCORES = 16'd1;
        step();
        step();
        check("reset_outs", {SD_TO_WRITE, WRITE_FINISH, SKIPPED, WRITE_ERROR}, 32'd0);
        check("reset_data", 32'(WRITE_DATA), 32'd0);
        check("reset_addr", SD_WRITE_ADDRESS, ADDR);
        RESET = 1'b0;
        TO_SAVE = 1'b0;
    endtask

    task automatic wait_bus_idle();
        int n = 0;
        while (SD_IS_WRITING && n < 100) begin
            step();
            n++;
        end
        if (SD_IS_WRITING) check("bus_idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_finish(input int budget, output int cycles);
        cycles = 0;
        while (!WRITE_FINISH && cycles < budget) begin
            step();
            cycles++;
        end
        if (!WRITE_FINISH) check("finish_timeout", 32'd0, 32'd1);
    endtask

    // One game: the expected outcome depends only on whether cur beats prev.
    task automatic run_game(input logic [15:0] cur, input logic [15:0] prev,
                            input int busy, input int init_delay);
        bit wrote;
        int cyc;
        int pulses_done;
        wrote = (cur > prev);
        do_reset();
        wait_bus_idle();
        busy_len = busy;
        sd_respond = 1'b1;
        req_pulses = 0;
        exp_data = cur;
        CURRENT_SCORES = cur;
        PREVIOUS_SCORES = prev;
        SD_HAS_INITIALIZED = (init_delay == 0);
        TO_SAVE = 1'b1;
        for (int i = 0; i < init_delay; i++) begin
            step();
            check("uninit_quiet", {SD_TO_WRITE, WRITE_FINISH, SKIPPED}, 32'd0);
        end
        SD_HAS_INITIALIZED = 1'b1;
        step();
        check("lat_cycle1", {SD_TO_WRITE, WRITE_FINISH}, 32'd0);
        CURRENT_SCORES = 16'($urandom);
        PREVIOUS_SCORES = 16'($urandom);
        TO_SAVE = 1'($urandom_range(0, 1));
        step();
        if (wrote) check("lat_req", 32'(SD_TO_WRITE), 32'd1);
        else check("lat_skip", {WRITE_FINISH, SKIPPED, SD_TO_WRITE}, 32'b110);
        wait_finish(200, cyc);
        check("final_data", 32'(WRITE_DATA), 32'(cur));
        check("final_skipped", 32'(SKIPPED), 32'(!wrote));
        check("final_error", 32'(WRITE_ERROR), 32'd0);
        check("final_to_write", 32'(SD_TO_WRITE), 32'd0);
        step();
        pulses_done = req_pulses;
        check("req_pulses", pulses_done, wrote ? 1 : 0);
        CURRENT_SCORES = 16'hFFFF;
        PREVIOUS_SCORES = 16'h0000;
        TO_SAVE = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("done_ignore_pulses", req_pulses, pulses_done);
        check("done_ignore_outs", {WRITE_FINISH, SD_TO_WRITE}, 32'b10);
        check("done_ignore_data", 32'(WRITE_DATA), 32'(cur));
        TO_SAVE = 1'b0;
    endtask

    task automatic mid_write_reset();
        int n;
        do_reset();
        wait_bus_idle();
        busy_len = 20;
        sd_respond = 1'b1;
        exp_data = 16'd120;
        CURRENT_SCORES = 16'd120;
        PREVIOUS_SCORES = 16'd80;
        TO_SAVE = 1'b1;
        n = 0;
        while (!SD_IS_WRITING && n < 20) begin
            step();
            n++;
        end
        check("mid_busy_seen", 32'(SD_IS_WRITING), 32'd1);
        step();
        step();
        CURRENT_SCORES = 16'd5;
        step();
        check("wait_data_hold", 32'(WRITE_DATA), 32'd120);
        check("wait_outs", {SD_TO_WRITE, WRITE_FINISH}, 32'd0);
        RESET = 1'b1;
        TO_SAVE = 1'b1;
        step();
        check("mid_reset_outs", {SD_TO_WRITE, WRITE_FINISH, SKIPPED, WRITE_ERROR}, 32'd0);
        check("mid_reset_data", 32'(WRITE_DATA), 32'd0);
        RESET = 1'b0;
        TO_SAVE = 1'b0;
        run_game(16'd200, 16'd10, 3, 0);
    endtask

`ifdef SCORES_WRITE_TIMEOUT_EN
    task automatic timeout_game();
        int cyc;
        do_reset();
        wait_bus_idle();
        sd_respond = 1'b0;
        req_pulses = 0;
        exp_data = 16'd120;
        CURRENT_SCORES = 16'd120;
        PREVIOUS_SCORES = 16'd80;
        TO_SAVE = 1'b1;
        step();
        step();
        check("to_first_req", 32'(SD_TO_WRITE), 32'd1);
        wait_finish(300, cyc);
        check("to_total_cycles", cyc, 4 * REQ_TO + 3);
        check("to_outs", {WRITE_FINISH, WRITE_ERROR, SKIPPED}, 32'b110);
        step();
        check("to_windows", req_pulses, 4);
        sd_respond = 1'b1;
        TO_SAVE = 1'b0;
    endtask
`endif

    initial begin
        logic [15:0] c, p;
        int mode;
        run_game(16'd120, 16'd80, 5, 0);
        run_game(16'd80, 16'd80, 5, 0);
        run_game(16'd300, 16'd100, 2, 50);
        mid_write_reset();
        run_game(16'd0, 16'd0, 1, 0);
        run_game(16'hFFFF, 16'hFFFE, 1, 0);
        run_game(16'h8000, 16'h7FFF, 4, 1);
        run_game(16'h7FFF, 16'h8000, 4, 0);
        for (int g = 0; g < 10; g++) begin
            c = 16'($urandom);
            mode = $urandom_range(0, 3);
            case (mode)
                0: p = c;
                1: p = c - 16'd1;
                2: p = c + 16'd1;
                default: p = 16'($urandom);
            endcase
            run_game(c, p, $urandom_range(1, 6), $urandom_range(0, 3));
        end
`ifdef SCORES_WRITE_TIMEOUT_EN
        timeout_game();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
